// File: rtl/mawg_step_sequencer.sv
// Step scheduler for the MAWG: walks a programmed table of {freq_ctrl, wave_sel, dwell}
// entries, holding each for its dwell time, optionally looping, with start/stop control.
module mawg_step_sequencer #(
  parameter int DEPTH   = 8,
  parameter int CTRL_W  = 32,
  parameter int DWELL_W = 24,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [CTRL_W-1:0]  wr_ctrl,
  input  logic [1:0]         wr_wave,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               busy,
  output logic [CTRL_W-1:0]  freq_ctrl,
  output logic [1:0]         wave_sel,
  output logic [IDX_W-1:0]   step_idx,
  output logic               step_strobe,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, FETCH, DWELL} state_t;

  state_t             state, state_nxt;
  logic [CTRL_W-1:0]  tbl_ctrl  [DEPTH];
  logic [1:0]         tbl_wave  [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];
  logic [IDX_W-1:0]   idx, idx_nxt, last_lat;
  logic               loop_lat;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               latch_cfg, apply, done_nxt;

  // A zero dwell still occupies one DWELL cycle.
  function automatic logic [DWELL_W-1:0] dwell_floor(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_ctrl[i]  <= '0;
        tbl_wave[i]  <= '0;
        tbl_dwell[i] <= '0;
      end
    end else if (wr_en) begin
      tbl_ctrl[wr_addr]  <= wr_ctrl;
      tbl_wave[wr_addr]  <= wr_wave;
      tbl_dwell[wr_addr] <= wr_dwell;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    latch_cfg = 1'b0;
    apply     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          latch_cfg = 1'b1;
          idx_nxt   = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          apply     = 1'b1;
          cnt_nxt   = dwell_floor(tbl_dwell[idx]);
          state_nxt = DWELL;
        end
      end
      DWELL: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (cnt == DWELL_W'(1)) begin
          if (idx != last_lat) begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = FETCH;
          end else if (loop_lat) begin
            idx_nxt   = '0;
            state_nxt = FETCH;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - DWELL_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      last_lat    <= '0;
      loop_lat    <= 1'b0;
      freq_ctrl   <= '0;
      wave_sel    <= '0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      step_strobe <= apply;
      done        <= done_nxt;
      if (latch_cfg) begin
        last_lat <= last_idx;
        loop_lat <= loop_en;
      end
      // Outputs only move when a step is applied; they hold through IDLE and stop.
      if (apply) begin
        freq_ctrl <= tbl_ctrl[idx];
        wave_sel  <= tbl_wave[idx];
        step_idx  <= idx;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mawg_step_sequencer.sv
// Self-checking bench for mawg_step_sequencer: step tables drive a strobe/done scoreboard,
// plus hand sequences for stop, priority, write collision and async reset.
module tb_mawg_step_sequencer;
  localparam int DEPTH   = 8;
  localparam int CTRL_W  = 32;
  localparam int DWELL_W = 24;
  localparam int IDX_W   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_en = 1'b0;
  logic [IDX_W-1:0]   wr_addr = '0;
  logic [CTRL_W-1:0]  wr_ctrl = '0;
  logic [1:0]         wr_wave = '0;
  logic [DWELL_W-1:0] wr_dwell = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop_en = 1'b0;
  logic [IDX_W-1:0]   last_idx = '0;
  logic               busy;
  logic [CTRL_W-1:0]  freq_ctrl;
  logic [1:0]         wave_sel;
  logic [IDX_W-1:0]   step_idx;
  logic               step_strobe;
  logic               done;

  always #5 clk = ~clk;

  mawg_step_sequencer #(.DEPTH(DEPTH), .CTRL_W(CTRL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ctrl(wr_ctrl),
    .wr_wave(wr_wave), .wr_dwell(wr_dwell), .start(start), .stop(stop), .loop_en(loop_en),
    .last_idx(last_idx), .busy(busy), .freq_ctrl(freq_ctrl), .wave_sel(wave_sel),
    .step_idx(step_idx), .step_strobe(step_strobe), .done(done)
  );

  // One table row: what to program and how long that step must stay applied.
  typedef struct {
    logic [IDX_W-1:0]   idx;
    logic [CTRL_W-1:0]  ctrl;
    logic [1:0]         wave;
    logic [DWELL_W-1:0] dwell;
    int                 hold;
  } vec_t;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [CTRL_W-1:0] ctrl;
    logic [1:0]        wave;
    int                cyc;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n0, t_end;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (step_strobe) begin
      if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e = sb.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("freq_ctrl", freq_ctrl, e.ctrl);
        chk("wave_sel", wave_sel, e.wave);
        chk("step_idx", step_idx, e.idx);
        chk("busy_in_step", busy, 1);
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic write_entry(input vec_t v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = v.idx; wr_ctrl = v.ctrl; wr_wave = v.wave; wr_dwell = v.dwell;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic program_table();
    for (int k = 0; k < vt.size(); k++) write_entry(vt[k]);
  endtask

  // Queue expected strobes (walking vt cyclically) starting from the start edge at n0.
  task automatic push_steps(input int base, input int count, input bit with_done, output int t_out);
    vec_t v;
    int   t;
    t = base + 1;
    for (int k = 0; k < count; k++) begin
      v = vt[k % vt.size()];
      sb.push_back('{v.idx, v.ctrl, v.wave, t});
      t += v.hold;
    end
    if (with_done) done_q.push_back(t - 1);
    t_out = t;
  endtask

  // Drives start for one edge; n0 is the cyc value seen in the FETCH cycle after that edge.
  task automatic start_seq(input logic [IDX_W-1:0] last, input logic lp, input int count,
                           input bit with_done);
    @(negedge clk);
    last_idx = last; loop_en = lp; n0 = cyc + 1;
    push_steps(n0, count, with_done, t_end);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || done_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0 || done_q.size() != 0) begin
      chk("timeout_pending", sb.size() + done_q.size(), 0);
      sb.delete();
      done_q.delete();
    end
  endtask

  task automatic load_pass_table();
    vt.delete();
    vt.push_back('{3'd0, 32'h1000, 2'd1, 24'd3, 4});
    vt.push_back('{3'd1, 32'h2000, 2'd2, 24'd5, 6});
    vt.push_back('{3'd2, 32'h3000, 2'd3, 24'd1, 2});
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_freq_ctrl", freq_ctrl, 0);
    chk("rst_wave_sel", wave_sel, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_step_strobe", step_strobe, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    // Single pass
    load_pass_table();
    program_table();
    start_seq(3'd2, 1'b0, 3, 1'b1);
    drain(100);
    repeat (3) @(negedge clk);
    chk("hold_freq_ctrl", freq_ctrl, 32'h3000);
    chk("hold_wave_sel", wave_sel, 3);
    chk("hold_step_idx", step_idx, 2);
    chk("hold_busy", busy, 0);

    // Loop then stop
    start_seq(3'd2, 1'b1, 5, 1'b0);
    drain(100);
    @(negedge clk);
    chk("loop_busy_before_stop", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_hold_freq", freq_ctrl, 32'h2000);
    chk("stop_hold_idx", step_idx, 1);
    repeat (12) @(negedge clk);
    chk("stop_stays_idle", busy, 0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", busy, 0);
    repeat (4) @(negedge clk);
    chk("start_stop_still_idle", busy, 0);

    // start pulse while busy is ignored
    start_seq(3'd2, 1'b0, 3, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; loop_en = 1'b1; last_idx = 3'd5;
    @(negedge clk);
    start = 1'b0;
    drain(100);
    repeat (3) @(negedge clk);
    chk("busy_start_ignored", busy, 0);

    // Dwell zero across the whole table, last_idx = 7
    vt.delete();
    for (int k = 0; k < DEPTH; k++)
      vt.push_back('{IDX_W'(k), 32'hA000 + 32'(k * 'h11), 2'(k % 4), 24'd0, 2});
    program_table();
    start_seq(3'd7, 1'b0, 8, 1'b1);
    drain(100);

    // Write collision on entry 1 during its FETCH
    load_pass_table();
    program_table();
    start_seq(3'd2, 1'b1, 4, 1'b0);
    sb.push_back('{3'd1, 32'h2BAD, 2'd0, t_end});
    while (cyc < n0 + 4) @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd1; wr_ctrl = 32'h2BAD; wr_wave = 2'd0; wr_dwell = 24'd5;
    @(negedge clk);
    wr_en = 1'b0;
    drain(100);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("collision_stop_busy", busy, 0);

    // Async reset mid-DWELL clears outputs and table
    load_pass_table();
    program_table();
    start_seq(3'd2, 1'b0, 1, 1'b0);
    drain(20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_freq_ctrl", freq_ctrl, 0);
    chk("arst_wave_sel", wave_sel, 0);
    chk("arst_step_idx", step_idx, 0);
    chk("arst_step_strobe", step_strobe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vt.delete();
    vt.push_back('{3'd0, 32'h0, 2'd0, 24'd0, 2});
    start_seq(3'd0, 1'b0, 1, 1'b1);
    drain(20);
    repeat (2) @(negedge clk);
    chk("post_reset_table_zero", freq_ctrl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
